// File: rtl/port_sram_xbar_if.sv
// Port/bank crossbar bundle: request, grant, write data and routed bank outputs.
// master = port side, slave = crossbar side.
interface port_sram_xbar_if #(
  parameter int NUM_PORTS  = 16,
  parameter int NUM_SRAMS  = 32,
  parameter int DATA_WIDTH = 16
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int SW = $clog2(NUM_SRAMS);

  logic [NUM_PORTS-1:0]            req_vld;
  logic [NUM_PORTS*SW-1:0]         req_sram;
  logic [NUM_PORTS-1:0]            req_gnt;
  logic [NUM_PORTS-1:0]            xfer_vld;
  logic [NUM_PORTS-1:0]            xfer_eop;
  logic [NUM_PORTS*DATA_WIDTH-1:0] xfer_data;
  logic [NUM_PORTS-1:0]            xfer_err;
  logic [NUM_SRAMS-1:0]            sram_vld;
  logic [NUM_SRAMS-1:0]            sram_eop;
  logic [NUM_SRAMS*DATA_WIDTH-1:0] sram_data;
  logic [NUM_SRAMS*PW-1:0]         sram_src;
  logic [NUM_SRAMS-1:0]            bank_busy;

  modport master (
    output req_vld, req_sram,
    output xfer_vld, xfer_eop, xfer_data,
    input  req_gnt, xfer_err,
    input  sram_vld, sram_eop, sram_data,
    input  sram_src, bank_busy
  );

  modport slave (
    input  req_vld, req_sram,
    input  xfer_vld, xfer_eop, xfer_data,
    output req_gnt, xfer_err,
    output sram_vld, sram_eop, sram_data,
    output sram_src, bank_busy
  );
endinterface

// File: rtl/port_sram_xbar.sv
// Write-port to SRAM-bank crossbar with per-bank round-robin ownership.
// Define XBAR_OUTPUT_REG_EN to register the routed bank outputs.
module port_sram_xbar #(
  parameter int NUM_PORTS  = 16,
  parameter int NUM_SRAMS  = 32,
  parameter int DATA_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  port_sram_xbar_if.slave bus
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int SW = $clog2(NUM_SRAMS);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t [NUM_SRAMS-1:0]          st;
  logic [NUM_SRAMS-1:0][PW-1:0]    owner;
  logic [NUM_SRAMS-1:0][PW-1:0]    rr;
  logic [NUM_PORTS-1:0]            gnt_q;
  logic [NUM_PORTS-1:0]            err_q;

  logic [NUM_PORTS-1:0]            owns;
  logic [NUM_PORTS-1:0]            claimed;
  logic [NUM_SRAMS-1:0]            pick_v;
  logic [NUM_SRAMS-1:0][PW-1:0]    pick_p;
  logic [NUM_SRAMS-1:0]            rel;

  logic [NUM_SRAMS-1:0]                 r_vld, r_eop;
  logic [NUM_SRAMS-1:0][DATA_WIDTH-1:0] r_data;
  logic [NUM_SRAMS-1:0]                 o_vld, o_eop;
  logic [NUM_SRAMS-1:0][DATA_WIDTH-1:0] o_data;

  // ports currently holding a bank
  always_comb begin
    owns = '0;
    for (int b = 0; b < NUM_SRAMS; b++)
      if (st[b] == OWNED) owns[owner[b]] = 1'b1;
  end

  // per-bank round-robin pick; lower banks claim a port first
  always_comb begin
    int idx;
    idx = 0;
    claimed = '0;
    pick_v = '0;
    pick_p = '0;
    for (int b = 0; b < NUM_SRAMS; b++) begin
      if (st[b] == IDLE) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx = int'(rr[b]) + k;
          if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
          if (!pick_v[b] && bus.req_vld[idx] &&
              !owns[idx] && !claimed[idx] &&
              bus.req_sram[idx*SW +: SW] == SW'(b)) begin
            pick_v[b] = 1'b1;
            pick_p[b] = PW'(idx);
          end
        end
      end
      if (pick_v[b]) claimed[pick_p[b]] = 1'b1;
    end
  end

  // route the owner's write stream onto its bank
  always_comb begin
    r_vld = '0;
    r_eop = '0;
    r_data = '0;
    for (int b = 0; b < NUM_SRAMS; b++) begin
      if (st[b] == OWNED) begin
        r_vld[b] = bus.xfer_vld[owner[b]];
        r_eop[b] = bus.xfer_eop[owner[b]];
        r_data[b] = bus.xfer_data[int'(owner[b])*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef XBAR_OUTPUT_REG_EN
  logic [NUM_SRAMS-1:0]                 q_vld, q_eop;
  logic [NUM_SRAMS-1:0][DATA_WIDTH-1:0] q_data;

  // one-cycle output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_vld <= '0;
      q_eop <= '0;
      q_data <= '0;
    end else begin
      q_vld <= r_vld;
      q_eop <= r_eop;
      q_data <= r_data;
    end
  end

  assign o_vld = q_vld;
  assign o_eop = q_eop;
  assign o_data = q_data;
`else
  assign o_vld = r_vld;
  assign o_eop = r_eop;
  assign o_data = r_data;
`endif

  // release once the last word leaves on the bank side
  always_comb begin
    rel = '0;
    for (int b = 0; b < NUM_SRAMS; b++)
      rel[b] = (st[b] == OWNED) && o_vld[b] && o_eop[b];
  end

  // bank FSMs, grant pulses and orphan-write errors
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q <= '0;
      err_q <= '0;
      for (int b = 0; b < NUM_SRAMS; b++) begin
        st[b] <= IDLE;
        owner[b] <= '0;
        rr[b] <= '0;
      end
    end else begin
      gnt_q <= claimed;
      err_q <= bus.xfer_vld & ~owns;
      for (int b = 0; b < NUM_SRAMS; b++) begin
        unique case (st[b])
          IDLE: if (pick_v[b]) begin
            st[b] <= OWNED;
            owner[b] <= pick_p[b];
            rr[b] <= (pick_p[b] == PW'(NUM_PORTS-1)) ?
                     '0 : pick_p[b] + PW'(1);
          end
          OWNED: if (rel[b]) st[b] <= IDLE;
          default: st[b] <= IDLE;
        endcase
      end
    end
  end

  // bank status view
  always_comb begin
    bus.bank_busy = '0;
    for (int b = 0; b < NUM_SRAMS; b++)
      bus.bank_busy[b] = (st[b] == OWNED);
  end

  assign bus.req_gnt = gnt_q;
  assign bus.xfer_err = err_q;
  assign bus.sram_vld = o_vld;
  assign bus.sram_eop = o_eop;
  assign bus.sram_data = o_data;
  assign bus.sram_src = owner;
endmodule

// File: tb/tb_port_sram_xbar.sv
// Directed bench for port_sram_xbar in its default build.
// Inputs change 1 unit after posedge; outputs are checked 1 unit later.
module tb_port_sram_xbar;
  localparam int NP = 16;
  localparam int NS = 32;
  localparam int DW = 16;
  localparam int PW = 4;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  port_sram_xbar_if #(.NUM_PORTS(NP), .NUM_SRAMS(NS),
    .DATA_WIDTH(DW)) bus ();

  port_sram_xbar #(.NUM_PORTS(NP), .NUM_SRAMS(NS),
    .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.req_vld = '0;
    bus.req_sram = '0;
    bus.xfer_vld = '0;
    bus.xfer_eop = '0;
    bus.xfer_data = '0;
    rst_n = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (bus.req_gnt !== 16'h0 || bus.xfer_err !== 16'h0) begin
      errors++;
      $display("FAIL rst_gnt_err: got %h/%h want 0/0",
               bus.req_gnt, bus.xfer_err);
    end
    checks++;
    if (bus.bank_busy !== 32'h0 || bus.sram_vld !== 32'h0 ||
        bus.sram_eop !== 32'h0) begin
      errors++;
      $display("FAIL rst_bank: busy %h vld %h eop %h want 0",
               bus.bank_busy, bus.sram_vld, bus.sram_eop);
    end
    checks++;
    if (bus.sram_data !== '0 || bus.sram_src !== '0) begin
      errors++;
      $display("FAIL rst_data_src: got %h / %h want 0",
               bus.sram_data, bus.sram_src);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_grant;
    bus.req_vld[3] = 1'b1;
    bus.req_sram[3*SW +: SW] = 5'd5;
    #1;
    checks++;
    if (bus.req_gnt !== 16'h0) begin
      errors++;
      $display("FAIL gnt_c0: got %h want 0000", bus.req_gnt);
    end
    tick();
    checks++;
    if (bus.req_gnt !== 16'h0008) begin
      errors++;
      $display("FAIL gnt_c1: got %h want 0008", bus.req_gnt);
    end
    checks++;
    if (bus.bank_busy !== 32'h0000_0020 ||
        bus.sram_src[5*PW +: PW] !== 4'd3) begin
      errors++;
      $display("FAIL gnt_own: busy %h src %0d want 00000020 3",
               bus.bank_busy, bus.sram_src[5*PW +: PW]);
    end
    bus.req_vld[3] = 1'b0;
    tick();
    checks++;
    if (bus.req_gnt !== 16'h0) begin
      errors++;
      $display("FAIL gnt_pulse: got %h want 0000", bus.req_gnt);
    end
    bus.xfer_vld[3] = 1'b1;
    bus.xfer_eop[3] = 1'b1;
    bus.xfer_data[3*DW +: DW] = 16'hABCD;
    #1;
    checks++;
    if (bus.sram_vld !== 32'h20 || bus.sram_eop !== 32'h20 ||
        bus.sram_data[5*DW +: DW] !== 16'hABCD) begin
      errors++;
      $display("FAIL gnt_route: vld %h eop %h data %h want 20 20 abcd",
               bus.sram_vld, bus.sram_eop, bus.sram_data[5*DW +: DW]);
    end
    tick();
    bus.xfer_vld = '0;
    bus.xfer_eop = '0;
    bus.xfer_data = '0;
    #1;
    checks++;
    if (bus.bank_busy !== 32'h0 || bus.sram_src[5*PW +: PW] !== 4'd3 ||
        bus.xfer_err !== 16'h0) begin
      errors++;
      $display("FAIL gnt_release: busy %h src %0d err %h want 0 3 0",
               bus.bank_busy, bus.sram_src[5*PW +: PW], bus.xfer_err);
    end
  endtask

  task automatic test_round_robin;
    tick();
    bus.req_vld[2] = 1'b1;
    bus.req_vld[9] = 1'b1;
    bus.req_sram[2*SW +: SW] = 5'd7;
    bus.req_sram[9*SW +: SW] = 5'd7;
    tick();
    checks++;
    if (bus.req_gnt !== 16'h0004 || bus.sram_src[7*PW +: PW] !== 4'd2) begin
      errors++;
      $display("FAIL rr_first: gnt %h src %0d want 0004 2",
               bus.req_gnt, bus.sram_src[7*PW +: PW]);
    end
    bus.req_vld[2] = 1'b0;
    tick();
    checks++;
    if (bus.req_gnt !== 16'h0) begin
      errors++;
      $display("FAIL rr_held: gnt %h want 0000", bus.req_gnt);
    end
    bus.xfer_vld[2] = 1'b1;
    bus.xfer_eop[2] = 1'b1;
    tick();
    bus.xfer_vld = '0;
    bus.xfer_eop = '0;
    #1;
    checks++;
    if (bus.req_gnt !== 16'h0 || bus.bank_busy !== 32'h0) begin
      errors++;
      $display("FAIL rr_gap: gnt %h busy %h want 0 0",
               bus.req_gnt, bus.bank_busy);
    end
    tick();
    checks++;
    if (bus.req_gnt !== 16'h0200 || bus.sram_src[7*PW +: PW] !== 4'd9 ||
        bus.bank_busy !== 32'h80) begin
      errors++;
      $display("FAIL rr_second: gnt %h src %0d busy %h want 0200 9 80",
               bus.req_gnt, bus.sram_src[7*PW +: PW], bus.bank_busy);
    end
    bus.req_vld[9] = 1'b0;
    bus.xfer_vld[9] = 1'b1;
    bus.xfer_eop[9] = 1'b1;
    tick();
    bus.xfer_vld = '0;
    bus.xfer_eop = '0;
  endtask

  task automatic test_stream;
    tick();
    bus.req_vld[4] = 1'b1;
    bus.req_sram[4*SW +: SW] = 5'd1;
    tick();
    checks++;
    if (bus.req_gnt !== 16'h0010) begin
      errors++;
      $display("FAIL st_gnt: got %h want 0010", bus.req_gnt);
    end
    bus.req_vld[4] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.xfer_vld[4] = 1'b1;
      bus.xfer_eop[4] = (i == 4);
      bus.xfer_data[4*DW +: DW] = 16'(i);
      #1;
      checks++;
      if (bus.sram_vld[1] !== 1'b1 || bus.sram_eop[1] !== (i == 4) ||
          bus.sram_data[1*DW +: DW] !== 16'(i)) begin
        errors++;
        $display("FAIL st_word%0d: vld %b eop %b data %h want 1 %b %h",
                 i, bus.sram_vld[1], bus.sram_eop[1],
                 bus.sram_data[1*DW +: DW], (i == 4), 16'(i));
      end
      tick();
    end
    bus.xfer_vld = '0;
    bus.xfer_eop = '0;
    bus.xfer_data = '0;
    #1;
    checks++;
    if (bus.bank_busy !== 32'h0 || bus.sram_vld !== 32'h0 ||
        bus.sram_data !== '0) begin
      errors++;
      $display("FAIL st_idle: busy %h vld %h want 0 0",
               bus.bank_busy, bus.sram_vld);
    end
  endtask

  task automatic test_orphan_err;
    tick();
    bus.xfer_vld[6] = 1'b1;
    bus.xfer_data[6*DW +: DW] = 16'h5555;
    #1;
    checks++;
    if (bus.sram_vld !== 32'h0) begin
      errors++;
      $display("FAIL err_drop: sram_vld %h want 0", bus.sram_vld);
    end
    tick();
    bus.xfer_vld = '0;
    bus.xfer_data = '0;
    #1;
    checks++;
    if (bus.xfer_err !== 16'h0040) begin
      errors++;
      $display("FAIL err_set: got %h want 0040", bus.xfer_err);
    end
    tick();
    checks++;
    if (bus.xfer_err !== 16'h0) begin
      errors++;
      $display("FAIL err_clear: got %h want 0000", bus.xfer_err);
    end
  endtask

  task automatic test_second_bank;
    bus.req_vld[0] = 1'b1;
    bus.req_sram[0*SW +: SW] = 5'd2;
    tick();
    checks++;
    if (bus.req_gnt !== 16'h0001 || bus.bank_busy !== 32'h4) begin
      errors++;
      $display("FAIL sb_gnt: gnt %h busy %h want 0001 4",
               bus.req_gnt, bus.bank_busy);
    end
    bus.req_sram[0*SW +: SW] = 5'd3;
    tick();
    checks++;
    if (bus.req_gnt !== 16'h0 || bus.bank_busy !== 32'h4) begin
      errors++;
      $display("FAIL sb_block: gnt %h busy %h want 0 4",
               bus.req_gnt, bus.bank_busy);
    end
    bus.xfer_vld[0] = 1'b1;
    bus.xfer_eop[0] = 1'b1;
    tick();
    bus.xfer_vld = '0;
    bus.xfer_eop = '0;
    #1;
    checks++;
    if (bus.req_gnt !== 16'h0 || bus.bank_busy !== 32'h0) begin
      errors++;
      $display("FAIL sb_gap: gnt %h busy %h want 0 0",
               bus.req_gnt, bus.bank_busy);
    end
    tick();
    checks++;
    if (bus.req_gnt !== 16'h0001 || bus.bank_busy !== 32'h8) begin
      errors++;
      $display("FAIL sb_regnt: gnt %h busy %h want 0001 8",
               bus.req_gnt, bus.bank_busy);
    end
    bus.req_vld[0] = 1'b0;
    bus.xfer_vld[0] = 1'b1;
    bus.xfer_eop[0] = 1'b1;
    tick();
    bus.xfer_vld = '0;
    bus.xfer_eop = '0;
  endtask

  task automatic test_mid_reset;
    tick();
    bus.req_vld[1] = 1'b1;
    bus.req_sram[1*SW +: SW] = 5'd0;
    tick();
    checks++;
    if (bus.req_gnt !== 16'h0002) begin
      errors++;
      $display("FAIL mr_gnt: got %h want 0002", bus.req_gnt);
    end
    bus.req_vld[1] = 1'b0;
    bus.xfer_vld[1] = 1'b1;
    bus.xfer_data[1*DW +: DW] = 16'h1234;
    #1;
    checks++;
    if (bus.sram_vld !== 32'h1 || bus.sram_data[DW-1:0] !== 16'h1234) begin
      errors++;
      $display("FAIL mr_mid: vld %h data %h want 1 1234",
               bus.sram_vld, bus.sram_data[DW-1:0]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.xfer_vld = '0;
    bus.xfer_data = '0;
    #1;
    checks++;
    if (bus.req_gnt !== 16'h0 || bus.xfer_err !== 16'h0 ||
        bus.bank_busy !== 32'h0 || bus.sram_vld !== 32'h0 ||
        bus.sram_eop !== 32'h0 || bus.sram_data !== '0 ||
        bus.sram_src !== '0) begin
      errors++;
      $display("FAIL mr_clear: gnt %h err %h busy %h vld %h eop %h want 0",
               bus.req_gnt, bus.xfer_err, bus.bank_busy,
               bus.sram_vld, bus.sram_eop);
    end
    bus.req_vld[1] = 1'b1;
    tick();
    checks++;
    if (bus.req_gnt !== 16'h0002 || bus.bank_busy !== 32'h1 ||
        bus.sram_src[PW-1:0] !== 4'd1) begin
      errors++;
      $display("FAIL mr_regnt: gnt %h busy %h src %0d want 0002 1 1",
               bus.req_gnt, bus.bank_busy, bus.sram_src[PW-1:0]);
    end
    bus.req_vld[1] = 1'b0;
    bus.xfer_vld[1] = 1'b1;
    bus.xfer_eop[1] = 1'b1;
    tick();
    bus.xfer_vld = '0;
    bus.xfer_eop = '0;
    #1;
    checks++;
    if (bus.bank_busy !== 32'h0) begin
      errors++;
      $display("FAIL mr_release: busy %h want 0", bus.bank_busy);
    end
  endtask

  initial begin
    test_reset();
    test_grant();
    test_round_robin();
    test_stream();
    test_orphan_err();
    test_second_bank();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/port_sram_xbar.md
PORT_SRAM_XBAR -- requirements
Module: port_sram_xbar

Interface
REQ-001 SHALL have parameter NUM_PORTS, 16, number of write ports (2..32).
REQ-002 SHALL have parameter NUM_SRAMS, 32, number of SRAM banks (2..64).
REQ-003 SHALL have parameter DATA_WIDTH, 16, transfer word width.
REQ-004 SHALL define derived widths PW=$clog2(NUM_PORTS) and SW=$clog2(NUM_SRAMS).
REQ-005 SHALL have clk  input  1  clock; all state changes on the rising edge.
REQ-006 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have req_vld  input  NUM_PORTS  per-port bank request, held until granted.
REQ-008 SHALL have req_sram  input  NUM_PORTS*SW  requested bank index; port p uses slice [p*SW +: SW].
REQ-009 SHALL have req_gnt  output  NUM_PORTS  one-cycle grant pulse.
REQ-010 SHALL have xfer_vld / xfer_eop  input  NUM_PORTS each  word valid / last word of packet.
REQ-011 SHALL have xfer_data  input  NUM_PORTS*DATA_WIDTH  port write data.
REQ-012 SHALL have sram_vld / sram_eop  output  NUM_SRAMS each  routed valid / last word.
REQ-013 SHALL have sram_data  output  NUM_SRAMS*DATA_WIDTH  routed data.
REQ-014 SHALL have sram_src  output  NUM_SRAMS*PW  owning port index of each bank.
REQ-015 SHALL have bank_busy  output  NUM_SRAMS  bank is OWNED.
REQ-016 SHALL have xfer_err  output  NUM_PORTS  registered pulse: xfer_vld from a port owning no bank.

Function
REQ-017 Each bank SHALL run a two-state FSM: IDLE, OWNED.
REQ-018 In IDLE, bank b SHALL consider only ports with req_vld=1, req_sram==b, and no bank currently owned.
REQ-019 Among eligible ports, bank b SHALL pick the first at or after its round-robin pointer rr[b], wrapping from NUM_PORTS-1 to 0.
REQ-020 On a pick in cycle t, at the edge ending t: bank goes OWNED, owner latched, rr[b] = winner+1 mod NUM_PORTS, and req_gnt[winner]=1 for cycle t+1 only.
REQ-021 A port SHALL own at most one bank; if two banks would grant the same port in one cycle, only the lower-indexed bank grants and the other stays IDLE.
REQ-022 req_sram values >= NUM_SRAMS SHALL be ignored: no grant, no error.
REQ-023 In OWNED, sram_vld/sram_data/sram_eop of bank b SHALL equal the owner's xfer_vld/xfer_data/xfer_eop in the same cycle (combinational, zero latency). Exception: REQ-032.
REQ-024 In IDLE, sram_vld and sram_eop SHALL be 0 and sram_data all-zero.
REQ-025 Owner xfer_vld=1 with xfer_eop=1 in cycle t SHALL return the bank to IDLE at the edge ending t; the bank can arbitrate in t+1, so the earliest next grant pulse is in t+2.
REQ-026 A port's release and a new request from the same port in one cycle SHALL be legal; that request becomes eligible in the following cycle.
REQ-027 sram_src SHALL hold the last owner index after release; bank_busy=1 exactly while OWNED.
REQ-028 xfer_vld=1 from a port owning no bank SHALL set xfer_err for the next cycle; that data SHALL be dropped.

Reset
REQ-029 On rst_n=0 at a clock edge: all banks IDLE, all rr pointers 0, all owners 0, and req_gnt, xfer_err, bank_busy, sram_vld, sram_eop, sram_data, sram_src 0.
REQ-030 Reset mid-packet SHALL abandon the packet silently: no sram_eop and no error generated.

Configuration
REQ-031 Macro XBAR_OUTPUT_REG_EN SHALL select the output timing.
REQ-032 With XBAR_OUTPUT_REG_EN defined, sram_vld/sram_data/sram_eop SHALL be registered (1-cycle latency); release then takes effect 1 cycle later than in REQ-025.
REQ-033 With XBAR_OUTPUT_REG_EN undefined, outputs SHALL be combinational as in REQ-023; arbitration timing SHALL be identical in both builds.

Verification
REQ-034 Port 3 requests bank 5 in cycle 0 -> req_gnt[3]=1 in cycle 1; bank_busy[5]=1; sram_src[5]=3.
REQ-035 Ports 2 and 9 request bank 7 with rr[7]=0 -> port 2 granted; after port 2 sends eop -> port 9 granted two cycles after eop.
REQ-036 Port 4 (owner of bank 1) streams 0x0001..0x0004 with eop on 0x0004 -> sram_data[1] carries the same sequence with zero latency, or one cycle later with XBAR_OUTPUT_REG_EN; then bank 1 returns to IDLE.
REQ-037 Port 6 asserts xfer_vld with no grant -> xfer_err[6]=1 for one cycle; every sram_vld stays 0.
REQ-038 rst_n=0 while bank 0 is OWNED mid-packet -> the next cycle shows all outputs 0; a new request for bank 0 is granted normally.
REQ-039 Port 0 owns bank 2 and requests bank 3 -> no grant until port 0's eop, then req_gnt[0]=1 two cycles after the eop cycle.
